nios2_mult_cell_seq: RTL

Parametrised, area-saving multiply cell for the Nios II custom datapath: one registered 16x16 unsigned multiplier is time-shared across all 16-bit limb pairs of the two operands. It produces either the low word or the signed/unsigned high word of a WIDTH x WIDTH product. It sits beside the existing fast multiply cell in the CPU execute stage and is used where DSP blocks are scarce. Operands are accepted with a valid/ready handshake, and the result returns as a one-cycle valid pulse.

---
 rtl/nios2_mult_cell_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/nios2_mult_cell_seq.sv
// Sequential WIDTH x WIDTH multiply cell: one registered 16x16 multiplier walks all limb pairs.
// Optional MULT_CELL_LOWSKIP_EN: in MUL mode, skip limb pairs that cannot reach the low word.
module nios2_mult_cell_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    output logic [WIDTH-1:0] result
);
    localparam int N = WIDTH / 16;

    localparam logic [1:0] M_MUL  = 2'b00;
    localparam logic [1:0] M_XSS  = 2'b01;
    localparam logic [1:0] M_XSU  = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIX} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0]   a_q, b_q;
    logic [1:0]         mode_q;
    logic [2:0]         li, lj;
    logic [31:0]        prod;
    logic [3:0]         prod_sh;
    logic               prod_vld;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod_ext;
    logic [15:0]        a_limb, b_limb;
    logic               row_end, last_pair;
    logic [WIDTH-1:0]   hi_fix;

    assign in_ready = (state == IDLE);
    assign a_limb   = a_q[16*int'(li) +: 16];
    assign b_limb   = b_q[16*int'(lj) +: 16];

    // A row ends early when only the low word is wanted and the optimisation is built in.
    always_comb begin
        row_end = (li == 3'(N-1));
`ifdef MULT_CELL_LOWSKIP_EN
        if (mode_q == M_MUL)
            row_end = (({1'b0, li} + {1'b0, lj}) == 4'(N-1));
`endif
        last_pair = row_end && (lj == 3'(N-1));
    end

    always_comb begin
        prod_ext        = '0;
        prod_ext[31:0]  = prod;
        prod_ext        = prod_ext << (16*int'(prod_sh));
    end

    // Signed high word = unsigned high word minus the other operand for each negative signed input.
    always_comb begin
        hi_fix = acc[2*WIDTH-1:WIDTH];
        if ((mode_q == M_XSS || mode_q == M_XSU) && a_q[WIDTH-1])
            hi_fix = hi_fix - b_q;
        if (mode_q == M_XSS && b_q[WIDTH-1])
            hi_fix = hi_fix - a_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = ISSUE;
            ISSUE:   if (last_pair) state_nxt = DRAIN;
            DRAIN:   state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= '0;
            li        <= '0;
            lj        <= '0;
            prod      <= '0;
            prod_sh   <= '0;
            prod_vld  <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            out_valid <= 1'b0;
            prod_vld  <= 1'b0;
            if (prod_vld)
                acc <= acc + prod_ext;
            case (state)
                IDLE: if (in_valid) begin
                    a_q    <= src1;
                    b_q    <= src2;
                    mode_q <= mode;
                    acc    <= '0;
                    li     <= '0;
                    lj     <= '0;
                end
                ISSUE: begin
                    prod     <= a_limb * b_limb;
                    prod_sh  <= {1'b0, li} + {1'b0, lj};
                    prod_vld <= 1'b1;
                    if (row_end) begin
                        li <= '0;
                        lj <= lj + 3'd1;
                    end else begin
                        li <= li + 3'd1;
                    end
                end
                FIX: begin
                    out_valid <= 1'b1;
                    result    <= (mode_q == M_MUL) ? acc[WIDTH-1:0] : hi_fix;
                end
                default: ;
            endcase
        end
    end
endmodule
